// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
// Optional feature macro: MULDIV_UNSIGNED_EN (adds multu/divu support).
package muldiv_pkg;

  // Default operand width; HI and LO are each this wide.
  localparam int MULDIV_WIDTH = 32;

  // Encoding of multordivE.
  localparam logic MULDIV_MUL = 1'b0;
  localparam logic MULDIV_DIV = 1'b1;

  // Sequencer states: idle, one iteration per cycle, sign fix / writeback.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Width of the iteration counter for a given operand width.
  function automatic int muldiv_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int MULDIV_CNT_W = muldiv_cnt_w(MULDIV_WIDTH);

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage interface of the HI/LO multiply/divide unit.
// Optional feature macro: MULDIV_UNSIGNED_EN (adds the unsignedE control).
//
// Handshake: startE is a single-cycle launch request. It is accepted only in
// a cycle where busy is 0; a startE seen while busy is 1 is dropped. busy rises
// the cycle after an accepted start and stays high through the cycle in which
// done pulses. hi/lo are stable whenever done is 0 and take their new values
// in the done cycle.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic             multordivE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
`ifdef MULDIV_UNSIGNED_EN
  logic             unsignedE;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues operations, observes status and results.
  modport master (
`ifdef MULDIV_UNSIGNED_EN
    output unsignedE,
`endif
    output startE,
    output multordivE,
    output srcaE,
    output srcbE,
    input  busy,
    input  done,
    input  hi,
    input  lo
  );

  // Unit side.
  modport slave (
`ifdef MULDIV_UNSIGNED_EN
    input  unsignedE,
`endif
    input  startE,
    input  multordivE,
    input  srcaE,
    input  srcbE,
    output busy,
    output done,
    output hi,
    output lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
// Multiply: {acc, qm} is the 2W-bit product accumulator with the multiplier in
//   the low half; add opnd (multiplicand) to the high half when qm[0] is set,
//   then shift the whole accumulator right by one.
// Divide: acc is the partial remainder, qm holds the dividend bits still to be
//   consumed and collects quotient bits from the bottom; opnd is the divisor.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] qm,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] qm_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Single shift-add or shift-trial-subtract iteration.
  always_comb begin
    sum     = '0;
    rem_sh  = '0;
    trial   = '0;
    acc_nxt = acc;
    qm_nxt  = qm;
    if (op == MULDIV_MUL) begin
      // Carry out of the add becomes the new MSB after the right shift.
      sum     = {1'b0, acc} + (qm[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      acc_nxt = sum[WIDTH:1];
      qm_nxt  = {sum[0], qm[WIDTH-1:1]};
    end else begin
      // Remainder stays below the divisor, so W+1 bits hold the shifted value
      // and bit W of the difference is a reliable borrow flag.
      rem_sh = {acc, qm[WIDTH-1]};
      trial  = rem_sh - {1'b0, opnd};
      if (!trial[WIDTH]) begin
        acc_nxt = trial[WIDTH-1:0];
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
      end
      qm_nxt = {qm[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, on
// operand magnitudes with a final sign-fix cycle. busy feeds the hazard unit.
// Optional feature macro: MULDIV_UNSIGNED_EN (unsignedE selects multu/divu,
// which skip the magnitude and sign-fix steps). Without it every op is signed.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus,
  output state_t        dbg_state
);

  localparam int                CNT_W    = muldiv_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q,    state_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic               op_q,       op_d;
  logic               res_neg_q,  res_neg_d;   // negate product / quotient
  logic               rem_neg_q,  rem_neg_d;   // negate remainder
  logic [WIDTH-1:0]   acc_q,      acc_d;
  logic [WIDTH-1:0]   qm_q,       qm_d;
  logic [WIDTH-1:0]   opnd_q,     opnd_d;
  logic [WIDTH-1:0]   srca_q,     srca_d;      // raw dividend for divide-by-zero
  logic [WIDTH-1:0]   hi_q,       hi_d;
  logic [WIDTH-1:0]   lo_q,       lo_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   step_qm;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Signedness of the incoming operation.
`ifdef MULDIV_UNSIGNED_EN
  assign signed_op = ~bus.unsignedE;
`else
  assign signed_op = 1'b1;
`endif

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // exactly its magnitude when read as an unsigned W-bit number.
  always_comb begin
    a_mag = (signed_op && bus.srcaE[WIDTH-1]) ? (~bus.srcaE + 1'b1) : bus.srcaE;
    b_mag = (signed_op && bus.srcbE[WIDTH-1]) ? (~bus.srcbE + 1'b1) : bus.srcbE;
  end

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op      (op_q),
    .acc     (acc_q),
    .qm      (qm_q),
    .opnd    (opnd_q),
    .acc_nxt (step_acc),
    .qm_nxt  (step_qm)
  );

  // Sign correction of the finished magnitude result, including the
  // divide-by-zero convention (all-ones quotient, dividend passed to HI).
  always_comb begin
    prod_fix = {acc_q, qm_q};
    fix_hi   = acc_q;
    fix_lo   = qm_q;
    if (op_q == MULDIV_MUL) begin
      if (res_neg_q) begin
        prod_fix = ~{acc_q, qm_q} + 1'b1;
      end
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (opnd_q == '0) begin
      fix_hi = srca_q;
      fix_lo = '1;
    end else begin
      fix_hi = rem_neg_q ? (~acc_q + 1'b1) : acc_q;
      fix_lo = res_neg_q ? (~qm_q + 1'b1) : qm_q;
    end
  end

  // Next-state, counter and datapath register updates.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    acc_d     = acc_q;
    qm_d      = qm_q;
    opnd_d    = opnd_q;
    srca_d    = srca_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.startE) begin
          op_d      = bus.multordivE;
          res_neg_d = signed_op & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
          rem_neg_d = signed_op & bus.srcaE[WIDTH-1];
          srca_d    = bus.srcaE;
          acc_d     = '0;
          count_d   = '0;
          if (bus.multordivE == MULDIV_MUL) begin
            qm_d   = b_mag;   // multiplier shifts out of the low half
            opnd_d = a_mag;   // multiplicand
          end else begin
            qm_d   = a_mag;   // dividend shifts in, quotient builds up
            opnd_d = b_mag;   // divisor
          end
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = step_acc;
        qm_d    = step_qm;
        count_d = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          state_d = FIX;
        end
      end
      FIX: begin
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= MULDIV_MUL;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      qm_q      <= '0;
      opnd_q    <= '0;
      srca_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      acc_q     <= acc_d;
      qm_q      <= qm_d;
      opnd_q    <= opnd_d;
      srca_q    <= srca_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Outputs: the corrected result is visible in the FIX cycle itself and is
  // held in hi_q/lo_q from the following cycle on.
  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.done  = (state_q == FIX);
    bus.hi    = (state_q == FIX) ? fix_hi : hi_q;
    bus.lo    = (state_q == FIX) ? fix_lo : lo_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: fixed-latency timing, hold, busy/done
// behaviour, signed corner cases, ignored starts, mid-operation reset and
// back-to-back random operations against a 2W-bit arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int              vec_cnt  = 0;
  int              miss_cnt = 0;
  logic [2*W-1:0]  exp_q[$];
  logic [W-1:0]    cur_hi = '0;
  logic [W-1:0]    cur_lo = '0;

  // Reference model: {hi, lo} from wide signed arithmetic.
  function automatic logic [2*W-1:0] model(input logic op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic uns);
    logic signed [2*W-1:0] sa, sb, r, qv, rv;
    sa = uns ? {{W{1'b0}}, a} : {{W{a[W-1]}}, a};
    sb = uns ? {{W{1'b0}}, b} : {{W{b[W-1]}}, b};
    if (op == MULDIV_MUL) begin
      r = sa * sb;
      return r;
    end
    if (b == '0) return {a, {W{1'b1}}};
    qv = sa / sb;
    rv = sa % sb;
    return {rv[W-1:0], qv[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.startE     = 1'b0;
    bus.multordivE = 1'b0;
    bus.srcaE      = '0;
    bus.srcbE      = '0;
`ifdef MULDIV_UNSIGNED_EN
    bus.unsignedE  = 1'b0;
`endif
  endtask

  // Launch one operation at cycle 0 and follow it to cycle W+2, checking
  // busy/done every cycle, hold of hi/lo, and the result at the done pulse.
  // poke_cyc >= 1 injects a bogus startE for one cycle while busy.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic uns, input string name, input int poke_cyc);
    logic [2*W-1:0] exp;
    logic           exp_busy, exp_done;
    exp_q.push_back(model(op, a, b, uns));
    bus.startE     = 1'b1;
    bus.multordivE = op;
    bus.srcaE      = a;
    bus.srcbE      = b;
`ifdef MULDIV_UNSIGNED_EN
    bus.unsignedE  = uns;
`endif
    vec_cnt++;
    if (bus.busy !== 1'b0) begin
      miss_cnt++;
      $display("FAIL %s busy@start: got %b want 0", name, bus.busy);
    end
    for (int cyc = 1; cyc <= W + 2; cyc++) begin
      tick();
      if (cyc == 1) drive_idle();
      if (cyc == poke_cyc) begin
        bus.startE     = 1'b1;
        bus.multordivE = ~op;
        bus.srcaE      = $urandom;
        bus.srcbE      = $urandom;
      end
      if (poke_cyc > 0 && cyc == poke_cyc + 1) drive_idle();
      exp_busy = (cyc <= W + 1);
      exp_done = (cyc == W + 1);
      vec_cnt++;
      if (bus.busy !== exp_busy) begin
        miss_cnt++;
        $display("FAIL %s busy cyc %0d: got %b want %b", name, cyc, bus.busy, exp_busy);
      end
      vec_cnt++;
      if (bus.done !== exp_done) begin
        miss_cnt++;
        $display("FAIL %s done cyc %0d: got %b want %b", name, cyc, bus.done, exp_done);
      end
      if (cyc <= W) begin
        vec_cnt++;
        if (bus.hi !== cur_hi || bus.lo !== cur_lo) begin
          miss_cnt++;
          $display("FAIL %s hold cyc %0d: got %h_%h want %h_%h", name, cyc,
                   bus.hi, bus.lo, cur_hi, cur_lo);
        end
      end
      if (bus.done === 1'b1) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          miss_cnt++;
          $display("FAIL %s extra done cyc %0d: got result with empty queue want none", name, cyc);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.hi, bus.lo} !== exp) begin
            miss_cnt++;
            $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name,
                     bus.hi, bus.lo, exp[2*W-1:W], exp[W-1:0]);
          end
          cur_hi = exp[2*W-1:W];
          cur_lo = exp[W-1:0];
        end
      end
    end
    vec_cnt++;
    if (exp_q.size() != 0) begin
      miss_cnt++;
      $display("FAIL %s missing done: got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miss_cnt++;
      $display("FAIL reset busy/done: got %b/%b want 0/0", bus.busy, bus.done);
    end
    vec_cnt++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      miss_cnt++;
      $display("FAIL reset hi/lo: got %h/%h want 0/0", bus.hi, bus.lo);
    end
    vec_cnt++;
    if (dbg_state !== IDLE) begin
      miss_cnt++;
      $display("FAIL reset state: got %0d want %0d", dbg_state, IDLE);
    end
    reset = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    tick();
  endtask

  task automatic test_mult();
    run_op(MULDIV_MUL, 32'd7,        32'hFFFF_FFFD, 1'b0, "mul_7_m3",     0);
    run_op(MULDIV_MUL, 32'h8000_0000, 32'h8000_0000, 1'b0, "mul_min_min", 0);
    run_op(MULDIV_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul_m1_m1",   0);
    run_op(MULDIV_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "mul_mixed",   0);
    run_op(MULDIV_MUL, 32'h0,         32'h7FFF_FFFF, 1'b0, "mul_zero",    0);
  endtask

  task automatic test_div();
    run_op(MULDIV_DIV, 32'hFFFF_FFF9, 32'd2,         1'b0, "div_m7_2",     0);
    run_op(MULDIV_DIV, 32'd7,         32'hFFFF_FFFE, 1'b0, "div_7_m2",     0);
    run_op(MULDIV_DIV, 32'd100,       32'd0,         1'b0, "div_100_0",    0);
    run_op(MULDIV_DIV, 32'hFFFF_FF9C, 32'd0,         1'b0, "div_m100_0",   0);
    run_op(MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_m1",   0);
    run_op(MULDIV_DIV, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, "div_max_min",  0);
  endtask

  task automatic test_start_while_busy();
    run_op(MULDIV_MUL, 32'd12345, 32'hFFFF_FD5A, 1'b0, "busy_start", 5);
  endtask

  task automatic test_reset_mid();
    bus.startE     = 1'b1;
    bus.multordivE = MULDIV_DIV;
    bus.srcaE      = 32'd1000;
    bus.srcbE      = 32'd7;
    tick();
    drive_idle();
    for (int i = 2; i <= 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vec_cnt++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miss_cnt++;
      $display("FAIL mid_reset busy/done: got %b/%b want 0/0", bus.busy, bus.done);
    end
    vec_cnt++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      miss_cnt++;
      $display("FAIL mid_reset hi/lo: got %h/%h want 0/0", bus.hi, bus.lo);
    end
    cur_hi = '0;
    cur_lo = '0;
    run_op(MULDIV_DIV, 32'd1000, 32'd7, 1'b0, "after_reset", 0);
  endtask

  task automatic test_back_to_back();
    logic         op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 2))
        0:       b = W'($urandom_range(1, 16));
        1:       b = -W'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 1'b0, "b2b_rand", 0);
    end
  endtask

`ifdef MULDIV_UNSIGNED_EN
  task automatic test_unsigned();
    run_op(MULDIV_MUL, 32'hFFFF_FFFF, 32'd2, 1'b1, "multu", 0);
    run_op(MULDIV_DIV, 32'hFFFF_FFFF, 32'd2, 1'b1, "divu",  0);
    run_op(MULDIV_DIV, 32'h8000_0000, 32'd0, 1'b1, "divu_0", 0);
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_mult();
    test_div();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
`ifdef MULDIV_UNSIGNED_EN
    test_unsigned();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
